// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the shift-register scheduler.
package shift_sched_pkg;

    // Default shift word width and requester count
    localparam int unsigned DEF_BITS = 8;
    localparam int unsigned DEF_NREQ = 4;

    // Scheduler FSM encoding
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StGap   = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_sched_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping.
module rr_pick
    import shift_sched_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = clog2(DEF_NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IW-1:0]   o_idx,
    output logic            o_any
);

    logic        w_found;
    int unsigned w_cand;

    // Scan NREQ positions starting at the pointer; the first hit wins
    always_comb begin
        w_found = 1'b0;
        w_cand  = 0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            w_cand = (32'(i_ptr) + off) % NREQ;
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = IW'(w_cand);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one parallel-load/serial-out shifter among
// NREQ requesters, with inter-frame gap and end-of-shift watchdog.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int unsigned BITS  = DEF_BITS,
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned GAP   = 2,
    parameter int unsigned SLACK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*BITS-1:0]     req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     sh_load,
    output logic [BITS-1:0]          sh_d,
    input  logic                     sh_eos,
    output logic                     busy,
    output logic [clog2(NREQ)-1:0]   grant_id,
    output logic                     timeout_err
);

    localparam int unsigned IW      = clog2(NREQ);
    localparam int unsigned WDW     = clog2(BITS + SLACK + 1);
    localparam int unsigned GCW_RAW = clog2(GAP + 1);
    localparam int unsigned GCW     = (GCW_RAW < 1) ? 1 : GCW_RAW;

    localparam logic [WDW-1:0] WD_LAST  = WDW'(BITS + SLACK - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP == 0) ? 0 : GAP - 1);
    // With no gap configured, a finished shift goes straight back to idle
    localparam state_t AFTER_SHIFT = (GAP == 0) ? StIdle : StGap;

    state_t          r_state;
    state_t          w_state_d;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   w_ptr_next;
    logic [WDW-1:0]  r_wd;
    logic [WDW-1:0]  w_wd_d;
    logic [GCW-1:0]  r_gap;
    logic [GCW-1:0]  w_gap_d;
    logic            r_err;
    logic            w_err_set;
    logic [BITS-1:0] r_sh_d;
    logic [IW-1:0]   r_grant;
    logic            w_accept;

    logic [NREQ-1:0] w_pick_gnt;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic [BITS-1:0] w_word;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Select the winning requester's word from the packed input bus
    always_comb begin
        w_word = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_pick_gnt[i]) begin
                w_word = req_data[i*BITS +: BITS];
            end
        end
    end

    // Pointer moves just past the winner, wrapping at NREQ
    always_comb begin
        w_ptr_next = (w_pick_idx == IW'(NREQ - 1)) ? '0 : w_pick_idx + IW'(1);
    end

    // Next-state logic for the frame FSM, watchdog and gap counter
    always_comb begin
        w_state_d = r_state;
        w_wd_d    = r_wd;
        w_gap_d   = r_gap;
        w_err_set = 1'b0;
        w_accept  = 1'b0;
        unique case (r_state)
            StIdle: begin
                // rst gating keeps req_ready quiet while reset is held
                if (enable && w_pick_any && !rst) begin
                    w_accept  = 1'b1;
                    w_state_d = StLoad;
                end
            end
            StLoad: begin
                w_wd_d    = '0;
                w_state_d = StShift;
            end
            StShift: begin
                w_wd_d = r_wd + WDW'(1);
                // End-of-shift takes priority over a coincident timeout
                if (sh_eos) begin
                    w_gap_d   = '0;
                    w_state_d = AFTER_SHIFT;
                end else if (r_wd == WD_LAST) begin
                    w_err_set = 1'b1;
                    w_gap_d   = '0;
                    w_state_d = AFTER_SHIFT;
                end
            end
            StGap: begin
                if (r_gap == GAP_LAST) begin
                    w_gap_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_gap_d = r_gap + GCW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, counters, sticky error and captured grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_wd    <= '0;
            r_gap   <= '0;
            r_err   <= 1'b0;
            r_sh_d  <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_d;
            r_wd    <= w_wd_d;
            r_gap   <= w_gap_d;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_sh_d  <= w_word;
                r_grant <= w_pick_idx;
                r_ptr   <= w_ptr_next;
            end
        end
    end

    // Outputs decoded from state so reset clears them immediately
    always_comb begin
        req_ready   = w_accept ? w_pick_gnt : '0;
        sh_load     = (r_state == StLoad);
        busy        = (r_state != StIdle);
        sh_d        = r_sh_d;
        grant_id    = r_grant;
        timeout_err = r_err;
    end

endmodule

// File: tb/tb_shift_sched.sv
// Directed self-checking bench for shift_sched (BITS=8, NREQ=4, GAP=2, SLACK=4).
module tb_shift_sched;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        sh_load;
    logic [7:0]  sh_d;
    logic        sh_eos;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    shift_sched #(
        .BITS  (8),
        .NREQ  (4),
        .GAP   (2),
        .SLACK (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .sh_load     (sh_load),
        .sh_d        (sh_d),
        .sh_eos      (sh_eos),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called in SHIFT cycle 1; pulses sh_eos in SHIFT cycle n, returns in GAP cycle 1
    task automatic eos_after(input int n);
        repeat (n - 1) cyc();
        sh_eos = 1'b1;
        cyc();
        sh_eos = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Called in IDLE with inputs set; runs a full 8-bit frame and returns in IDLE
    task automatic frame(input string tag, input int exp_id, input logic [7:0] exp_data);
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << exp_id));
        cyc();
        check({tag, "_grant"}, 32'(grant_id), 32'(exp_id));
        check({tag, "_load"}, 32'(sh_load), 32'd1);
        check({tag, "_data"}, 32'(sh_d), 32'(exp_data));
        check({tag, "_noready"}, 32'(req_ready), 32'd0);
        cyc();
        eos_after(8);
        repeat (2) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        sh_eos    = 1'b0;
        cyc();
        cyc();

        // Reset values
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_load", 32'(sh_load), 32'd0);
        check("rst_shd", 32'(sh_d), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;

        // 1: single grant of requester 2
        req_data  = {8'h3C, 8'hA5, 8'h5A, 8'h11};
        enable    = 1'b1;
        req_valid = 4'b0100;
        #1;
        check("t1_ready", 32'(req_ready), 32'b0100);
        check("t1_idle_busy", 32'(busy), 32'd0);
        cyc();
        req_valid = 4'b0000;
        check("t1_load", 32'(sh_load), 32'd1);
        check("t1_shd", 32'(sh_d), 32'hA5);
        check("t1_gid", 32'(grant_id), 32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        cyc();
        check("t1_load_drop", 32'(sh_load), 32'd0);
        eos_after(8);
        check("t1_gap1_busy", 32'(busy), 32'd1);
        cyc();
        check("t1_gap2_busy", 32'(busy), 32'd1);
        cyc();
        check("t1_idle", 32'(busy), 32'd0);

        // 2: round-robin across all four requesters
        do_reset();
        req_valid = 4'b1111;
        frame("t2_f0", 0, 8'h11);
        frame("t2_f1", 1, 8'h5A);
        frame("t2_f2", 2, 8'hA5);
        frame("t2_f3", 3, 8'h3C);
        frame("t2_f4", 0, 8'h11);

        // 3: pointer at 3 with only requesters 0 and 1 valid
        do_reset();
        req_valid = 4'b0100;
        frame("t3_pre", 2, 8'hA5);
        req_valid = 4'b0011;
        frame("t3_f0", 0, 8'h11);
        frame("t3_f1", 1, 8'h5A);
        frame("t3_f2", 0, 8'h11);

        // 4: watchdog with no end-of-shift
        req_valid = 4'b0001;
        #1;
        check("t4_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = 4'b0000;
        cyc();
        repeat (11) cyc();
        check("t4_sh12_err", 32'(timeout_err), 32'd0);
        check("t4_sh12_busy", 32'(busy), 32'd1);
        cyc();
        check("t4_err_set", 32'(timeout_err), 32'd1);
        cyc();
        cyc();
        check("t4_idle", 32'(busy), 32'd0);
        req_valid = 4'b0010;
        #1;
        check("t4_next_ready", 32'(req_ready), 32'b0010);
        cyc();
        req_valid = 4'b0000;
        check("t4_next_gid", 32'(grant_id), 32'd1);
        cyc();
        eos_after(8);
        repeat (2) cyc();
        check("t4_err_sticky", 32'(timeout_err), 32'd1);
        check("t4_done_busy", 32'(busy), 32'd0);
        do_reset();
        check("t4_err_cleared", 32'(timeout_err), 32'd0);

        // 5a: enable low blocks grants
        enable    = 1'b0;
        req_valid = 4'b0001;
        #1;
        check("t5_dis_ready", 32'(req_ready), 32'd0);
        cyc();
        check("t5_dis_busy", 32'(busy), 32'd0);
        check("t5_dis_load", 32'(sh_load), 32'd0);

        // 5b: enable dropped mid-frame; frame still completes
        enable = 1'b1;
        #1;
        check("t5_en_ready", 32'(req_ready), 32'b0001);
        cyc();
        enable = 1'b0;
        cyc();
        eos_after(8);
        check("t5_gap_busy", 32'(busy), 32'd1);
        cyc();
        cyc();
        check("t5_done_busy", 32'(busy), 32'd0);
        check("t5_done_ready", 32'(req_ready), 32'd0);
        check("t5_done_err", 32'(timeout_err), 32'd0);
        cyc();
        check("t5_stay_idle", 32'(busy), 32'd0);

        // 5c: sh_eos coincident with the timeout cycle
        enable = 1'b1;
        #1;
        check("t5c_ready", 32'(req_ready), 32'b0001);
        cyc();
        req_valid = 4'b0000;
        cyc();
        repeat (11) cyc();
        sh_eos = 1'b1;
        cyc();
        sh_eos = 1'b0;
        check("t5c_err", 32'(timeout_err), 32'd0);
        check("t5c_gap_busy", 32'(busy), 32'd1);
        repeat (2) cyc();
        check("t5c_idle", 32'(busy), 32'd0);

        // 6: asynchronous reset in the middle of SHIFT
        req_valid = 4'b0100;
        #1;
        check("t6_ready", 32'(req_ready), 32'b0100);
        cyc();
        req_valid = 4'b1111;
        check("t6_gid", 32'(grant_id), 32'd2);
        cyc();
        cyc();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_load", 32'(sh_load), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_gid", 32'(grant_id), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd0);
        check("t6_rst_shd", 32'(sh_d), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("t6_post_ready", 32'(req_ready), 32'b0001);
        cyc();
        check("t6_post_gid", 32'(grant_id), 32'd0);
        check("t6_post_load", 32'(sh_load), 32'd1);
        check("t6_post_shd", 32'(sh_d), 32'h11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
